// File: rtl/seg_scan_driver.sv
// seg_scan_driver: samples the asynchronous ripple-counter output A,
// filters out transient codes, converts the settled value into two BCD
// digits and scans them onto one BCD bus with a one-hot digit select.
// Optional feature macro: SEG_ZERO_BLANK_EN blanks a leading-zero tens digit.
module seg_scan_driver #(
    parameter int SCAN_DIV   = 1000,
    parameter int STABLE_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] A,
    output logic [3:0] bcd_out,
    output logic [1:0] digit_sel,
    output logic       upd
);

    localparam logic [15:0] PRESC_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  STAB_TARGET = 4'(STABLE_CNT);

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } scan_state_t;

    logic [3:0]  s1_r;
    logic [3:0]  s2_r;
    logic [3:0]  cand_r;
    logic [3:0]  stab_r;
    logic [3:0]  held_r;
    logic        accept_s;
    logic        tens_s;
    logic [3:0]  ones_s;
    logic [15:0] presc_r;
    logic [15:0] presc_nxt_s;
    logic        wrap_s;
    scan_state_t state_r;
    scan_state_t state_nxt_s;
    logic [1:0]  sel_nxt_s;
    logic [3:0]  bcd_nxt_s;

    // Units digit of a 0..15 binary value; result is always 0..9.
    function automatic logic [3:0] bin_ones(input logic [3:0] bin);
        logic [3:0] res;
        if (bin >= 4'd10) begin
            res = bin - 4'd10;
        end else begin
            res = bin;
        end
        return res;
    endfunction

    // Two-flop synchronizer for the ripple counter bits; no logic in between.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_r <= 4'd0;
            s2_r <= 4'd0;
        end else begin
            s1_r <= A;
            s2_r <= s1_r;
        end
    end

    // Acceptance fires on the edge where the stability count reaches its target.
    always_comb begin
        accept_s = 1'b0;
        if ((s2_r == cand_r) && (stab_r == (STAB_TARGET - 4'd1))) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Stability filter: restart counting whenever the synchronized code moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_r <= 4'd0;
            stab_r <= STAB_TARGET;
        end else begin
            if (s2_r != cand_r) begin
                cand_r <= s2_r;
                stab_r <= 4'd0;
            end else if (stab_r < STAB_TARGET) begin
                stab_r <= stab_r + 4'd1;
            end else begin
                stab_r <= stab_r;
            end
        end
    end

    // Accepted value and its change pulse; stab resets saturated so no pulse after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_r <= 4'd0;
            upd    <= 1'b0;
        end else begin
            if (accept_s) begin
                held_r <= cand_r;
                upd    <= (cand_r != held_r);
            end else begin
                held_r <= held_r;
                upd    <= 1'b0;
            end
        end
    end

    // Binary to two-digit BCD split of the accepted value.
    always_comb begin
        tens_s = (held_r >= 4'd10);
        ones_s = bin_ones(held_r);
    end

    // Scan state and prescaler registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ONES;
            presc_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            presc_r <= presc_nxt_s;
        end
    end

    // Next-state logic: toggle the selected digit each time the prescaler wraps.
    always_comb begin
        wrap_s      = (presc_r == PRESC_LAST);
        presc_nxt_s = presc_r + 16'd1;
        state_nxt_s = state_r;
        if (wrap_s) begin
            presc_nxt_s = 16'd0;
        end else begin
            presc_nxt_s = presc_r + 16'd1;
        end
        case (state_r)
            ONES: begin
                if (wrap_s) begin
                    state_nxt_s = TENS;
                end else begin
                    state_nxt_s = ONES;
                end
            end
            TENS: begin
                if (wrap_s) begin
                    state_nxt_s = ONES;
                end else begin
                    state_nxt_s = TENS;
                end
            end
            default: begin
                state_nxt_s = ONES;
            end
        endcase
    end

    // Output decode from the current state and the current accepted value.
    always_comb begin
        sel_nxt_s = 2'b01;
        bcd_nxt_s = 4'd0;
        case (state_r)
            ONES: begin
                sel_nxt_s = 2'b01;
                bcd_nxt_s = ones_s;
            end
            TENS: begin
`ifdef SEG_ZERO_BLANK_EN
                if (tens_s) begin
                    sel_nxt_s = 2'b10;
                    bcd_nxt_s = {3'b000, tens_s};
                end else begin
                    sel_nxt_s = 2'b00;
                    bcd_nxt_s = 4'd0;
                end
`else
                sel_nxt_s = 2'b10;
                bcd_nxt_s = {3'b000, tens_s};
`endif
            end
            default: begin
                sel_nxt_s = 2'b01;
                bcd_nxt_s = 4'd0;
            end
        endcase
    end

    // Registered display outputs so the digit and its select always change together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_sel <= 2'b01;
            bcd_out   <= 4'd0;
        end else begin
            digit_sel <= sel_nxt_s;
            bcd_out   <= bcd_nxt_s;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display-side stage downstream of the 4-bit ripple counter. It samples the counter's asynchronous, ripple-settling output `A` into the system clock domain and rejects transient codes. It converts the settled binary value 0–15 into two BCD digits and time-multiplexes them onto a single 4-bit BCD bus feeding the BCD-to-7-segment decoder, with a one-hot digit-select bus driving the common pins of a two-digit display.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each digit stays selected. Legal range is 2..65535; the prescaler is 16 bits.
- `STABLE_CNT`, default 3: consecutive equal synchronized samples required before a value is accepted. Legal range is 1..15.
- `clk`  input  1: system clock; all state updates on the rising edge.
- `reset`  input  1: asynchronous, active-low reset; a low level forces every register to its reset value immediately.
- `A`  input  4: ripple counter output. It is asynchronous to `clk`, and its bits may change on different edges.
- `bcd_out`  output  4: BCD digit presented to the 7-segment decoder. Registered.
- `digit_sel`  output  2: one-hot digit enable, active-high. 2'b01 selects ones, 2'b10 selects tens, 2'b00 blanks. Registered.
- `upd`  output  1: single-cycle pulse when the accepted value changes. Registered.

## Operation
- Synchronizer: two flops, `A` -> `s1` -> `s2`, with no logic between them.
- Stability filter: candidate register `cand`[3:0] and counter `stab`[3:0]. On each edge:
  - If `s2` != `cand`: load `cand` <= `s2` and clear `stab` <= 0.
  - Else if `stab` < `STABLE_CNT`: increment `stab`.
  - Else: hold.
- Acceptance: on the edge where `stab` increments to `STABLE_CNT`, `held` <= `cand`. On that same edge, `upd` <= 1 if `cand` != `held`; `upd` is 0 on every other edge.
- Conversion is applied to `held`. `tens` = 1 if `held` >= 10, else 0. `ones` = `held` - 10 if `held` >= 10, else `held`. It is combinational from `held`, and `ones` never exceeds 9.
- Scan state machine: two states, ONES and TENS.
  - Prescaler `presc` counts 0..`SCAN_DIV`-1.
  - On the edge where `presc` == `SCAN_DIV`-1: `presc` <= 0 and the state toggles (ONES->TENS, TENS->ONES).
  - Otherwise `presc` increments.
- Output register, updated every edge from the current state and current `held`:
  - In ONES: `digit_sel` <= 2'b01 and `bcd_out` <= `ones`.
  - In TENS: `digit_sel` <= 2'b10 and `bcd_out` <= {3'b000, `tens`}. The blanking feature under Configuration can override this.
- Reset values: `s1`, `s2`, `cand`, `held` = 0; `stab` = `STABLE_CNT`, so no spurious `upd` after reset; `presc` = 0; state ONES; `digit_sel` = 2'b01; `bcd_out` = 0; `upd` = 0.

## Timing
- Input to accepted value:
  - `A` settles before edge 1. `s1` captures at edge 1, `s2` at edge 2, `cand` at edge 3 with `stab` = 0.
  - `held` and `upd` update at edge 3+`STABLE_CNT`, which is edge 6 for the default.
  - `bcd_out` shows the new digit at the following edge if that digit is currently selected.
- Glitch rejection: an `s2` value that lasts fewer than `STABLE_CNT`+1 consecutive samples is never accepted. Intermediate ripple codes are therefore discarded.
- Simultaneous events: a prescaler wrap and a `held` update on the same edge are independent. The next edge's outputs use the new state and the new `held` together, so there is never a mixed old/new digit in one cycle.
- Scan period is 2*`SCAN_DIV` cycles. `digit_sel` changes exactly one edge after each state toggle and is never two-hot.
- Reset mid-operation: outputs return to their reset values asynchronously. After release, the scan restarts in ONES with `presc` = 0, and the value is re-acquired with the full acceptance latency.

## Configuration
- `SEG_ZERO_BLANK_EN`:
  - Defined: in TENS with `tens` == 0, `digit_sel` <= 2'b00 and `bcd_out` <= 4'd0, so the display shows "7", not "07".
  - Not defined: the tens digit is always driven, with `digit_sel` = 2'b10 and `bcd_out` = `tens`.
  - Either way, the ONES digit is never blanked.

## Test plan
- Reset: hold `reset` low with `A` = 4'd9, then release. During reset `digit_sel` = 2'b01, `bcd_out` = 0, `upd` = 0. After release, `upd` pulses once at edge 6 (`held` 0->9).
- Settle to 13 with `SCAN_DIV` = 4: ONES phase gives `bcd_out` = 3 with `digit_sel` = 01; TENS phase gives `bcd_out` = 1 with `digit_sel` = 10. Phases alternate every 4 cycles.
- Leading zero, `A` = 7: with the macro, the TENS phase gives `digit_sel` = 00. Without the macro, the TENS phase gives `digit_sel` = 10 and `bcd_out` = 0.
- Ripple glitch: `A` goes 3->2 for 2 cycles->4 and holds, with `STABLE_CNT` = 3. Exactly one `upd` pulse occurs, `held` ends at 4, and 2 is never shown.
- Wrap: `A` steps 15->0. `held` ends at 0, `bcd_out` = 5 then 0 in ONES, and `upd` pulses once per accepted change.
- Reset mid-scan while in TENS with `A` = 12: outputs go immediately to 01/0. After release, 12 is re-accepted at edge 6.
